// File: rtl/bits_unpack_ctrl_if.sv
// Word-FIFO read port, bit-field request port and field delivery port of the bit unpacker.
// master drives the FIFO status/data and requests; slave is the unpacking controller.
interface bits_unpack_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int OUT_W  = 15,
  parameter int LEN_W  = 4,
  parameter int BUF_W  = 64
);
  localparam int CNT_W = $clog2(BUF_W + 1);

  logic              flush;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_rdata;
  logic              reqin;
  logic [LEN_W-1:0]  reqlen;
  logic              ready;
  logic              pushout;
  logic [LEN_W-1:0]  lenout;
  logic [OUT_W-1:0]  dataout;
  logic [CNT_W-1:0]  bits_avail;

  modport master (
    output flush, fifo_empty, fifo_rdata, reqin, reqlen,
    input  fifo_pop, ready, pushout, lenout, dataout, bits_avail
  );

  modport slave (
    input  flush, fifo_empty, fifo_rdata, reqin, reqlen,
    output fifo_pop, ready, pushout, lenout, dataout, bits_avail
  );
endinterface

// File: rtl/bits_unpack_ctrl.sv
// Prefetches 32-bit FIFO words into a 64-bit buffer and serves 0..15-bit MSB-first fields, one edge after acceptance.
// A request waits in PEND (ready low) until enough bits are buffered; FIFO pops are throttled to one word in flight.
module bits_unpack_ctrl #(
  parameter int WORD_W = 32,
  parameter int OUT_W  = 15,
  parameter int LEN_W  = 4,
  parameter int BUF_W  = 64
) (
  input logic               clock,
  input logic               reset,
  bits_unpack_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
  localparam logic [LEN_W-1:0] OUT_W_L = LEN_W'(OUT_W);

  logic [0:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pushout_q, pushout_d;
  logic [LEN_W-1:0] lenout_q, lenout_d;
  logic [OUT_W-1:0] dataout_q, dataout_d;

  logic             pop;
  logic             consume;
  logic [CNT_W-1:0] take;
  logic [CNT_W-1:0] cnt_after;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] word_ext;
  logic [OUT_W-1:0] top;

  // Buffer is MSB-aligned: buf_q[BUF_W-1] is the next stream bit, bits below count_q are zero.
  assign pop       = !inflight_q && (count_q <= CNT_W'(WORD_W)) && !bus.fifo_empty && !bus.flush;
  assign consume   = (state_q == ST_PEND) && (count_q >= CNT_W'(len_q));
  assign take      = consume ? CNT_W'(len_q) : '0;
  assign shifted   = buf_q << take;
  assign cnt_after = count_q - take;
  assign word_ext  = {bus.fifo_rdata, {(BUF_W-WORD_W){1'b0}}};
  assign top       = buf_q[BUF_W-1 -: OUT_W];

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    len_d      = len_q;
    pushout_d  = 1'b0;
    lenout_d   = lenout_q;
    dataout_d  = dataout_q;
    if (bus.flush) begin
      state_d    = ST_IDLE;
      buf_d      = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      buf_d   = shifted;
      count_d = cnt_after;
      // The arriving word lands right behind whatever survives this edge's consume.
      if (inflight_q) begin
        buf_d   = shifted | (word_ext >> cnt_after);
        count_d = cnt_after + CNT_W'(WORD_W);
      end
      inflight_d = pop;
      if (consume) begin
        pushout_d = 1'b1;
        lenout_d  = len_q;
        dataout_d = top >> (OUT_W_L - len_q);
        state_d   = ST_IDLE;
      end else if ((state_q == ST_IDLE) && bus.reqin) begin
        len_d   = bus.reqlen;
        state_d = ST_PEND;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      len_q      <= '0;
      pushout_q  <= 1'b0;
      lenout_q   <= '0;
      dataout_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      len_q      <= len_d;
      pushout_q  <= pushout_d;
      lenout_q   <= lenout_d;
      dataout_q  <= dataout_d;
    end
  end

  assign bus.fifo_pop   = pop;
  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.pushout    = pushout_q;
  assign bus.lenout     = lenout_q;
  assign bus.dataout    = dataout_q;
  assign bus.bits_avail = count_q;
endmodule

// File: doc/bits_unpack_ctrl.md
Name: bits_unpack_ctrl

Overview:
Controller that sequences a 32-bit word FIFO to serve variable-length bit-field requests of 0..15 bits. It pops words from the FIFO and holds them in an internal bit buffer. It answers each accepted request with a right-aligned field taken MSB-first from the stream. It sits between the word FIFO read port and the downstream bit consumer, and owns all FIFO pop decisions.

Parameters:
WORD_W, 32, FIFO word width (stream bits per pop)
OUT_W, 15, maximum field width / dataout width
LEN_W, 4, request length width
BUF_W, 64, internal bit buffer capacity (must be >= 2*WORD_W)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of buffer, pending request and in-flight word
fifo_empty  input  1  FIFO has no words
fifo_pop  output  1  combinational pop strobe to FIFO
fifo_rdata  input  WORD_W  FIFO read data, valid the cycle after the fifo_pop edge
reqin  input  1  request strobe
reqlen  input  LEN_W  requested field length, 0..15
ready  output  1  high when a request can be accepted (state IDLE)
pushout  output  1  one-cycle strobe: field valid
lenout  output  LEN_W  length of delivered field
dataout  output  OUT_W  delivered field, right-aligned, upper bits zero
bits_avail  output  7  current buffer fill count, 0..64

Behaviour:
- Reset (reset=0, asynchronous): count=0, inflight=0, state=IDLE, pushout=0, lenout=0, dataout=0. This gives ready=1 and fifo_pop=0.
- Stream order: bit 31 of each word is consumed first. A delivered field of length L has its first stream bit at dataout[L-1]; dataout[OUT_W-1:L]=0.
- Pop rule: fifo_pop = !inflight & (count <= 32) & !fifo_empty & !flush.
  - A pop at edge E sets inflight.
  - At edge E+1, fifo_rdata is appended at the buffer tail, count += 32, and inflight clears.
  - At most one word is in flight. Peak rate is one word per 2 cycles.
  - Prefetch is independent of requests.
- States: IDLE, PEND.
  - IDLE: ready=1. At an edge with reqin=1, latch reqlen into len and go to PEND. reqin while ready=0 is ignored and not queued.
  - PEND: at each edge, if count >= len (pre-edge value):
    - register pushout=1, lenout=len, dataout=top len bits of the buffer;
    - remove len bits, count -= len;
    - go to IDLE.
  - If count < len, stay in PEND.
- pushout is high for exactly one cycle; ready is 1 in that same cycle.
- Minimum latency: reqin sampled at edge E0, pushout high in the cycle after E1. A new request is accepted no sooner than the pushout cycle.
- len=0: delivered at the first PEND edge with lenout=0, dataout=0; count unchanged.
- Simultaneous append and consume at one edge: count_next = count + 32 - len. The pop rule guarantees count_next <= 64, so there is no overflow.
- lenout and dataout hold their last values when pushout=0.
- Field spanning a word boundary: handled transparently once count >= len.
- FIFO empty while PEND with count < len: remain in PEND indefinitely with no pushout, and resume when words arrive.
- Flush (synchronous, highest priority over every other event in that edge):
  - count=0, state=IDLE, pushout=0, inflight=0;
  - a word arriving the cycle after flush is discarded;
  - fifo_pop is held 0 during the flush cycle;
  - lenout and dataout hold their values.
- Reset asserted mid-operation: immediate return to reset values; any pending request and in-flight word are lost.

Test Plan:
- Reset, then push 0xA5C30F81 and wait for bits_avail=32. Send reqlen=4, then reqlen=8 -> two pushouts: lenout=4, dataout=0x000A; then lenout=8, dataout=0x005C; bits_avail=20.
- Continue: push 0x12345678 and let the prefetch append it. Send reqlen=15 -> dataout=0x187C. Then send reqlen=9 across the word boundary -> dataout=0x0011, lenout=9.
- Empty FIFO, send reqlen=5 -> ready=0, no pushout for 20 cycles. Then push 0xF8000000 -> fifo_pop pulses, and pushout follows with dataout=0x001F.
- reqlen=0 with an empty buffer -> pushout 2 cycles after reqin, lenout=0, dataout=0, bits_avail unchanged. reqin held high while ready=0 -> exactly one pushout per accepted request.
- FIFO holding 4 words, no requests -> exactly 2 pops, bits_avail=64, fifo_pop=0 thereafter. Consume 15+15+3 bits -> the next pop fires when bits_avail <= 32.
- Flush in the cycle after fifo_pop with a request pending -> bits_avail=0, ready=1, no pushout, arriving word discarded. Assert reset mid-PEND -> all outputs return to reset values immediately, without waiting for a clock edge.
